// File: rtl/multdiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

  // Widest operand the abs helper supports; must exceed WIDTH.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef struct packed {
    logic             neg;
    logic [MAX_W-1:0] mag;
  } abs_t;

  // x arrives sign-extended, so the magnitude of the most negative value is exact.
  function automatic abs_t abs_sign(input logic [MAX_W-1:0] x, input logic is_signed);
    abs_t r;
    r.neg = is_signed & x[MAX_W-1];
    r.mag = r.neg ? (~x + 1'b1) : x;
    return r;
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One BPC-bit iteration: shift-add multiply accumulate or restoring divide step.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  localparam int PW = WIDTH + BPC;

  logic [BPC-1:0]     digit;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    // Multiply: low half holds the unconsumed multiplier, high half the running sum.
    digit   = acc_i[BPC-1:0];
    prod    = PW'(opnd_i) * PW'(digit);
    sum     = PW'(acc_i[2*WIDTH-1:WIDTH]) + prod;
    mul_nxt = {sum, acc_i[WIDTH-1:BPC]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    rem = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    quo = acc_i[WIDTH-1:0];
    for (int i = 0; i < BPC; i++) begin
      rem = {rem[WIDTH-1:0], quo[WIDTH-1]};
      quo = {quo[WIDTH-2:0], 1'b0};
      if (rem >= {1'b0, opnd_i}) begin
        rem    = rem - {1'b0, opnd_i};
        quo[0] = 1'b1;
      end
    end
    div_nxt = {rem[WIDTH-1:0], quo};

    acc_o = div_mode ? div_nxt : mul_nxt;
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO registers.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dzf_q, dzf_d;

  logic               op_signed;
  logic               op_div;
  abs_t               a_abs, b_abs;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               unused_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   quo, rem;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);

  assign a_abs = abs_sign({{(MAX_W-WIDTH){a[WIDTH-1] & op_signed}}, a}, op_signed);
  assign b_abs = abs_sign({{(MAX_W-WIDTH){b[WIDTH-1] & op_signed}}, b}, op_signed);
  assign a_mag = a_abs.mag[WIDTH-1:0];
  assign b_mag = b_abs.mag[WIDTH-1:0];
  assign unused_mag = ^{a_abs.mag[MAX_W-1:WIDTH], b_abs.mag[MAX_W-1:WIDTH]};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  multdiv_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .div_mode (div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzf_d   = dzf_q;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !abort) begin
          div_d  = op_div;
          qneg_d = a_abs.neg ^ b_abs.neg;
          rneg_d = a_abs.neg;
          dzf_d  = op_div && (b == '0);
          cnt_d  = '0;
          if (op_div) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          // Divide by zero bypasses iteration; the result is staged directly.
          if (op_div && (b == '0)) begin
            acc_d   = {a, {WIDTH{1'b1}}};
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          dz_d   = dzf_q;
          if (dzf_q) begin
            {hi_d, lo_d} = acc_q;
          end else if (div_q) begin
            lo_d = qneg_q ? -quo : quo;
            hi_d = rneg_q ? -rem : rem;
          end else begin
            {hi_d, lo_d} = qneg_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    div_q  <= div_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dzf_q  <= dzf_d;
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign done  = done_q;
  assign dz    = dz_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: arithmetic reference model, decoupled done monitor.
module tb_multdiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        abort;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        ready, busy, done, dz;
  logic [31:0] hi, lo;

  multdiv_unit #(.WIDTH(32), .BPC(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic        z;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mhi   = 0;
  logic [31:0] mlo   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l,
                                    output logic z, output int lat);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx  = x;
    sy  = y;
    z   = 1'b0;
    lat = 9;
    h   = '0;
    l   = '0;
    case (o)
      2'b00: begin sp = longint'(sx) * longint'(sy); {h, l} = sp; end
      2'b01: begin up = {32'd0, x} * {32'd0, y}; {h, l} = up; end
      default: begin
        if (y == 32'd0) begin
          z = 1'b1; lat = 1; h = x; l = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            l = x; h = 32'd0;
          end else begin
            l = sx / sy; h = sx % sy;
          end
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("hi", hi, e.h);
          chk("lo", lo, e.l);
          chk("dz", {31'd0, dz}, {31'd0, e.z});
          chk("latency", cyc, e.due);
          mhi = e.h;
          mlo = e.l;
        end
      end else begin
        if (dz !== 1'b0) chk("dz_outside_done", {31'd0, dz}, 32'd0);
        if (sbq.size() != 0 && cyc > sbq[0].due) begin
          chk("missing_done", cyc, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
      if (busy !== ~ready) chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~ready});
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (ready !== 1'b1 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit track, input bit we_hi, input logic [31:0] wd);
    exp_t        n;
    logic [31:0] h, l;
    logic        z;
    int          lat;
    wait_ready();
    op = o; a = x; b = y; start = 1'b1;
    hi_we = we_hi; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    if (we_hi) begin
      chk("hi_we_at_start", hi, wd);
      mhi = wd;
    end
    if (track) begin
      ref_model(o, x, y, h, l, z, lat);
      n.h = h; n.l = l; n.z = z; n.due = cyc + lat;
      sbq.push_back(n);
    end
  endtask

  task automatic write_lo(input logic [31:0] v);
    wait_ready();
    lo_we = 1'b1; wdata = v;
    @(posedge clk); #1;
    lo_we = 1'b0;
    mlo = v;
    chk("mtlo", lo, mlo);
  endtask

  task automatic drain();
    int g = 0;
    while ((sbq.size() != 0 || ready !== 1'b1) && g < 60) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_pending", sbq.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(0, 6))
      0: pick = allow_zero ? 32'd0 : 32'd1;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h7FFF_FFFF;
      4: pick = $urandom_range(0, 15);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #2;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_done",  {31'd0, done},  32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic, issued back-to-back.
    issue(2'b00, 32'hFFFF_FFFD, 32'd5,         1'b1, 1'b0, '0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, '0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, '0);
    issue(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, '0);
    issue(2'b10, 32'h0000_1234, 32'd0,         1'b1, 1'b0, '0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, '0);
    issue(2'b11, 32'd77,        32'd0,         1'b1, 1'b0, '0);
    drain();

    // Abort in the third CALC cycle leaves HI/LO untouched.
    write_lo(32'hAAAA_5555);
    issue(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_lo", lo, 32'hAAAA_5555);
    chk("abort_hi", hi, mhi);
    repeat (12) begin @(posedge clk); #1; end

    // start together with abort in IDLE is ignored.
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ignored", {31'd0, ready}, 32'd1);

    issue(2'b00, 32'd3, 32'd4, 1'b1, 1'b0, '0);
    drain();

    // HI write while busy is dropped; HI write with an accepted start lands.
    issue(2'b01, 32'd7, 32'd9, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("hi_we_busy", hi, mhi);
    drain();
    issue(2'b11, 32'd100, 32'd7, 1'b1, 1'b1, 32'h0000_5A5A);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), pick(1'b1), pick($urandom_range(0, 5) == 0), 1'b1, 1'b0, '0);
    end
    drain();

    // Asynchronous reset mid-CALC.
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0, 1'b0, '0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    chk("async_rst_busy",  {31'd0, busy},  32'd0);
    chk("async_rst_done",  {31'd0, done},  32'd0);
    chk("async_rst_dz",    {31'd0, dz},    32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; owns the architectural HI/LO registers.
- Performs signed and unsigned multiply and divide at WIDTH bits.
- Processes BPC bits of the operand per cycle.
- Uses a start/ready/done handshake, with abort for pipeline flush, divide-by-zero detection and direct HI/LO writes (mthi/mtlo).

Parameters:
- WIDTH, 32, operand width; even, ≥ 8.
- BPC, 4, bits retired per iteration; must divide WIDTH; N = WIDTH/BPC iterations.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  request; accepted on an edge where start & ready
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled at accept
- a  in  WIDTH  multiplicand / dividend; sampled at accept
- b  in  WIDTH  multiplier / divisor; sampled at accept
- abort  in  1  flush; cancels the in-flight operation
- hi_we  in  1  write wdata to HI (mthi)
- lo_we  in  1  write wdata to LO (mtlo)
- wdata  in  WIDTH  data for hi_we/lo_we
- ready  out  1  unit can accept start
- busy  out  1  operation in flight (= ~ready)
- done  out  1  one-cycle pulse; hi/lo hold the new result
- dz  out  1  qualifies done: divide by zero occurred
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, ready=1, busy=0, done=0, dz=0, hi=0, lo=0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
  - IDLE: on start & ready, latch op and operands, take absolute values for signed ops, record result signs, clear iteration counter; go to CALC, ready=0.
  - CALC: one iteration per edge; counter counts 0..N-1; after iteration N-1 go to FIX.
  - FIX: apply sign correction, write hi/lo, done=1, dz as applicable; go to IDLE, ready=1.
- Latency: done and the new hi/lo are visible after edge N+1 counted from the accept edge (9 cycles for 32/4).
- Back-to-back: ready=1 in the done cycle, so a new start in that cycle is accepted.
- Multiply:
  - Shift-add, BPC bits of |b| per iteration into a 2*WIDTH accumulator.
  - Signed: negate the 2*WIDTH product if sign(a)^sign(b).
  - {hi,lo} = product.
- Divide:
  - Non-restoring or restoring, BPC quotient bits per iteration.
  - Quotient truncates toward zero; remainder takes the sign of the dividend; lo = quotient, hi = remainder.
- Divide by zero (b=0, div or divu):
  - Skip CALC; go directly to FIX.
  - done and dz after edge 1; lo = all-ones, hi = a unchanged.
- Signed overflow (div, a = most negative, b = -1): lo = a, hi = 0, dz=0; normal latency.
- Most-negative operands to mult are handled exactly; |x| is computed at WIDTH+1 bits.
- abort:
  - Asserted in CALC or FIX: next state IDLE, ready=1, no done; hi/lo unchanged.
  - Asserted in IDLE: ignored.
  - abort together with start in IDLE: start is ignored.
- hi_we/lo_we:
  - Honoured only when busy=0.
  - While busy they are ignored; the pipeline stalls on busy.
  - hi_we/lo_we in the same cycle as an accepted start: the write happens and the operation starts.
  - Writes are never simultaneous with a FIX write.
- done and dz are held 0 outside the done cycle.

Decomposition:
- Package multdiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum IDLE/CALC/FIX.
  - function for absolute value with sign output.
- Sub-module multdiv_step: combinational, one BPC-bit iteration (mult accumulate or divide partial-remainder update), selected by a mode bit. The top module holds the FSM, counter, operand/accumulator registers and HI/LO.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 -> done after edge 9; hi=0xFFFFFFFF, lo=0xFFFFFFF1; dz=0.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=0xFFFFFFFF, b=0x80000000 -> lo=1, hi=0x7FFFFFFF.
- div a=0x00001234, b=0 -> done after edge 1 with dz=1, lo=0xFFFFFFFF, hi=0x00001234. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Control:
  - mtlo 0xAAAA5555, then mult 3*4.
  - abort in 3rd CALC cycle -> no done; lo=0xAAAA5555; ready=1 next cycle.
  - hi_we while busy -> hi unchanged.
- Back-to-back and reset:
  - New start in the done cycle is accepted; second result is correct.
  - rst low mid-CALC -> all outputs at reset values immediately (asynchronously, before the next edge); no done after rst returns high.
